// File: rtl/tx_afe_seq.sv
// TX analog front-end power sequencer: CM generator up, settle, SC buffer up, settle, DAC code live; reverse on power-down.
// Optional macro TX_SEQ_RAMP_EN slews the DAC code by RAMP_STEP per cycle in ON and ramps it to zero before SC power-down.
module tx_afe_seq #(
    parameter int CM_SETTLE_CYC = 64,
    parameter int SC_SETTLE_CYC = 32,
    parameter int CNT_W         = 16,
    parameter int DAC_W         = 10
`ifdef TX_SEQ_RAMP_EN
    ,
    parameter int RAMP_STEP     = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tx_req,
    input  logic [DAC_W-1:0] i_dac_code,
    output logic             o_Tx_CM_en,
    output logic             o_Tx_SC_en,
    output logic [DAC_W-1:0] o_dac_code,
    output logic             o_tx_ready,
    output logic             o_busy,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_CM_UP = 3'd1,
        S_SC_UP = 3'd2,
        S_ON    = 3'd3,
        S_SC_DN = 3'd4,
        S_CM_DN = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CM_LOAD = CNT_W'(CM_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SC_LOAD = CNT_W'(SC_SETTLE_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cm_en_q, cm_en_d;
    logic               sc_en_q, sc_en_d;
    logic [DAC_W-1:0]   dac_q, dac_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               cnt_done;
    logic [CNT_W-1:0]   cnt_dec;

`ifdef TX_SEQ_RAMP_EN
    localparam logic [DAC_W-1:0]    STEP_U = RAMP_STEP[DAC_W-1:0];
    localparam logic signed [DAC_W:0] STEP_S = $signed({1'b0, STEP_U});

    // Difference is taken one bit wider and signed so neither direction can wrap.
    function automatic logic [DAC_W-1:0] ramp_step(input logic [DAC_W-1:0] cur,
                                                   input logic [DAC_W-1:0] tgt);
        logic signed [DAC_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            return cur + STEP_U;
        else if (diff < -STEP_S)
            return cur - STEP_U;
        else
            return tgt;
    endfunction
`endif

    assign cnt_done = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cm_en_d = 1'b0;
        sc_en_d = 1'b0;
        dac_d   = '0;
        ready_d = 1'b0;
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                if (i_tx_req) begin
                    state_d = S_CM_UP;
                    cnt_d   = CM_LOAD;
                    cm_en_d = 1'b1;
                end
            end
            S_CM_UP: begin
                cm_en_d = 1'b1;
                if (!i_tx_req) begin
                    state_d = S_CM_DN;
                    cnt_d   = CM_LOAD;
                    cm_en_d = 1'b0;
                end else if (cnt_done) begin
                    state_d = S_SC_UP;
                    cnt_d   = SC_LOAD;
                    sc_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_SC_UP: begin
                cm_en_d = 1'b1;
                sc_en_d = 1'b1;
                if (!i_tx_req) begin
                    state_d = S_SC_DN;
                    cnt_d   = SC_LOAD;
                    sc_en_d = 1'b0;
                end else if (cnt_done) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_ON: begin
                cm_en_d = 1'b1;
                sc_en_d = 1'b1;
                ready_d = 1'b1;
`ifdef TX_SEQ_RAMP_EN
                dac_d   = ramp_step(dac_q, i_dac_code);
`else
                dac_d   = i_dac_code;
`endif
                if (!i_tx_req) begin
                    state_d = S_SC_DN;
                    cnt_d   = SC_LOAD;
                    ready_d = 1'b0;
`ifdef TX_SEQ_RAMP_EN
                    // SC stays enabled while the code walks down to zero.
                    sc_en_d = 1'b1;
                    dac_d   = ramp_step(dac_q, '0);
`else
                    sc_en_d = 1'b0;
                    dac_d   = '0;
`endif
                end
            end
            S_SC_DN: begin
                cm_en_d = 1'b1;
`ifdef TX_SEQ_RAMP_EN
                if (sc_en_q) begin
                    // Counter is frozen until SC actually drops.
                    if (dac_q != '0) begin
                        sc_en_d = 1'b1;
                        dac_d   = ramp_step(dac_q, '0);
                    end
                end else if (cnt_done) begin
                    state_d = S_CM_DN;
                    cnt_d   = CM_LOAD;
                    cm_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_dec;
                end
`else
                if (cnt_done) begin
                    state_d = S_CM_DN;
                    cnt_d   = CM_LOAD;
                    cm_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_dec;
                end
`endif
            end
            S_CM_DN: begin
                if (cnt_done) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_OFF) && (state_d != S_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            cm_en_q <= 1'b0;
            sc_en_q <= 1'b0;
            dac_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cm_en_q <= cm_en_d;
            sc_en_q <= sc_en_d;
            dac_q   <= dac_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Tx_CM_en = cm_en_q;
    assign o_Tx_SC_en = sc_en_q;
    assign o_dac_code = dac_q;
    assign o_tx_ready = ready_q;
    assign o_busy     = busy_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_tx_afe_seq.sv
// Directed bench for tx_afe_seq at default parameters; ramp vectors selected by TX_SEQ_RAMP_EN.
module tb_tx_afe_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_tx_req = 1'b0;
    logic [9:0] i_dac_code = '0;
    logic       o_Tx_CM_en;
    logic       o_Tx_SC_en;
    logic [9:0] o_dac_code;
    logic       o_tx_ready;
    logic       o_busy;
    logic [2:0] o_state;

    int n_chk = 0;
    int n_err = 0;

    tx_afe_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_req   (i_tx_req),
        .i_dac_code (i_dac_code),
        .o_Tx_CM_en (o_Tx_CM_en),
        .o_Tx_SC_en (o_Tx_SC_en),
        .o_dac_code (o_dac_code),
        .o_tx_ready (o_tx_ready),
        .o_busy     (o_busy),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        #2;
        check("rst_state", o_state, 0);
        check("rst_cm", o_Tx_CM_en, 0);
        check("rst_sc", o_Tx_SC_en, 0);
        check("rst_dac", o_dac_code, 0);
        check("rst_ready", o_tx_ready, 0);
        check("rst_busy", o_busy, 0);
        #20 rst_n = 1'b1;
        tick(5);

        // Power-up: CM at first edge, SC 64 edges later, ready 32 after that.
        i_tx_req = 1'b1;
        tick(1);
        check("up_cm", o_Tx_CM_en, 1);
        check("up_sc0", o_Tx_SC_en, 0);
        check("up_state1", o_state, 1);
        check("up_busy", o_busy, 1);
        tick(63);
        check("cm_settle_sc", o_Tx_SC_en, 0);
        check("cm_settle_state", o_state, 1);
        tick(1);
        check("sc_rise", o_Tx_SC_en, 1);
        check("sc_state2", o_state, 2);
        tick(31);
        check("sc_settle_rdy", o_tx_ready, 0);
        check("sc_settle_busy", o_busy, 1);
        tick(1);
        check("rdy_rise", o_tx_ready, 1);
        check("on_state", o_state, 3);
        check("on_busy", o_busy, 0);
        check("on_cm", o_Tx_CM_en, 1);

`ifdef TX_SEQ_RAMP_EN
        i_dac_code = 10'd20;
        tick(1); check("ramp_up1", o_dac_code, 8);
        tick(1); check("ramp_up2", o_dac_code, 16);
        tick(1); check("ramp_up3", o_dac_code, 20);
        tick(1); check("ramp_hold", o_dac_code, 20);
        i_tx_req = 1'b0;
        tick(1);
        check("rdn_rdy", o_tx_ready, 0);
        check("rdn_dac1", o_dac_code, 12);
        check("rdn_sc1", o_Tx_SC_en, 1);
        check("rdn_state", o_state, 4);
        tick(1); check("rdn_dac2", o_dac_code, 4);
        tick(1);
        check("rdn_dac3", o_dac_code, 0);
        check("rdn_sc3", o_Tx_SC_en, 1);
        tick(1);
        check("rdn_sc_fall", o_Tx_SC_en, 0);
        check("rdn_cm", o_Tx_CM_en, 1);
        tick(31);
`else
        i_dac_code = 10'h155;
        tick(1); check("dac_155", o_dac_code, 10'h155);
        i_dac_code = 10'h2AA;
        tick(1); check("dac_2aa", o_dac_code, 10'h2AA);
        i_tx_req = 1'b0;
        tick(1);
        check("dn_rdy", o_tx_ready, 0);
        check("dn_dac", o_dac_code, 0);
        check("dn_sc", o_Tx_SC_en, 0);
        check("dn_cm", o_Tx_CM_en, 1);
        check("dn_state", o_state, 4);
        check("dn_busy", o_busy, 1);
        tick(31);
`endif
        check("scdn_end_cm", o_Tx_CM_en, 1);
        check("scdn_end_state", o_state, 4);
        tick(1);
        check("cm_fall", o_Tx_CM_en, 0);
        check("cmdn_state", o_state, 5);
        tick(63);
        check("cmdn_end_state", o_state, 5);
        tick(1);
        check("off_state", o_state, 0);
        check("off_busy", o_busy, 0);

        // Short request pulse aborts CM_UP; re-request inside CM_DN is ignored.
        i_tx_req = 1'b1;
        tick(1);
        check("abort_cm", o_Tx_CM_en, 1);
        tick(4);
        check("abort_state1", o_state, 1);
        i_tx_req = 1'b0;
        tick(1);
        check("abort_state5", o_state, 5);
        check("abort_cm0", o_Tx_CM_en, 0);
        check("abort_sc0", o_Tx_SC_en, 0);
        tick(10);
        i_tx_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 53; i++) begin
            tick(1);
            if (o_Tx_CM_en !== 1'b0 || o_Tx_SC_en !== 1'b0 || o_state !== 3'd5) bad++;
        end
        check("rereq_ignored", bad, 0);
        tick(1);
        check("rereq_off", o_state, 0);
        check("rereq_off_cm", o_Tx_CM_en, 0);
        tick(1);
        check("restart_state", o_state, 1);
        check("restart_cm", o_Tx_CM_en, 1);

        // Back to ON, then asynchronous reset between edges.
        tick(64);
        check("re_sc", o_Tx_SC_en, 1);
        tick(32);
        check("re_rdy", o_tx_ready, 1);
        i_dac_code = 10'h155;
        tick(2);
        check("re_dac_nz", (o_dac_code != 0), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_state", o_state, 0);
        check("arst_cm", o_Tx_CM_en, 0);
        check("arst_sc", o_Tx_SC_en, 0);
        check("arst_dac", o_dac_code, 0);
        check("arst_rdy", o_tx_ready, 0);
        check("arst_busy", o_busy, 0);
        i_tx_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_state", o_state, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_afe_seq.md
Name: tx_afe_seq

Overview:
- Power sequencer for the TX analog front end: the common-mode generator (CM enable) and the switched-cap buffer (SC enable plus DAC code).
- Enforces the ordering CM up, settle, SC up, settle, DAC code live. Power-down runs the same order in reverse.
- Sits between the digital TX control and the analog top; drives i_Tx_CM_en, i_Tx_SC_en and the DAC code path.

Parameters:
- CM_SETTLE_CYC, 64, cycles CM enable is held before SC enables (also the CM power-down wait); legal range 1..2^CNT_W-1.
- SC_SETTLE_CYC, 32, cycles SC enable is held before ready (also the SC power-down wait); legal range 1..2^CNT_W-1.
- CNT_W, 16, settle counter width.
- DAC_W, 10, DAC code width.
- RAMP_STEP, 8, maximum code change per cycle when TX_SEQ_RAMP_EN is defined.

Ports:
- clk  input  1  sequencer clock
- rst_n  input  1  asynchronous active-low reset
- i_tx_req  input  1  level request: 1 = TX powered, 0 = TX off
- i_dac_code  input  DAC_W  requested DAC code, unsigned
- o_Tx_CM_en  output  1  CM generator enable
- o_Tx_SC_en  output  1  SC buffer enable
- o_dac_code  output  DAC_W  DAC code to the SC path
- o_tx_ready  output  1  front end settled, code live
- o_busy  output  1  sequence in progress (state is not OFF or ON)
- o_state  output  3  encoded state for debug

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: state OFF (0), o_Tx_CM_en=0, o_Tx_SC_en=0, o_dac_code=0, o_tx_ready=0, o_busy=0, counter=0.
- Reset mid-sequence drops all enables in the same cycle. There is no graceful power-down on reset.
- States and encodings: OFF=0, CM_UP=1, SC_UP=2, ON=3, SC_DN=4, CM_DN=5. Values 6 and 7 are illegal and go to OFF on the next edge.
- Counter: on entry to a settle state it loads PARAM-1 and decrements each cycle. The state exits on the edge where counter==0, so each settle state lasts exactly PARAM cycles.
- OFF: i_tx_req=1 sampled -> CM_UP with o_Tx_CM_en=1 from the same edge.
- CM_UP:
  - Count done with req=1 -> SC_UP, o_Tx_SC_en=1.
  - req=0 -> CM_DN immediately; counter reloads CM_SETTLE_CYC-1.
- SC_UP:
  - Count done with req=1 -> ON, o_tx_ready=1.
  - req=0 -> SC_DN; counter reloads SC_SETTLE_CYC-1.
- ON:
  - o_dac_code <= i_dac_code, one cycle latency.
  - req=0 -> SC_DN; on that edge o_tx_ready=0 and o_dac_code=0.
- SC_DN:
  - Entry: o_Tx_SC_en=0, o_dac_code=0.
  - Count done -> CM_DN with o_Tx_CM_en=0.
- CM_DN: count done -> OFF.
- Power-down is not abortable. A request re-asserted during SC_DN or CM_DN is ignored until OFF. It is then re-sampled, so a full restart begins 1 cycle after OFF.
- Nominal timing: rising edge of o_Tx_CM_en to rising edge of o_tx_ready = CM_SETTLE_CYC+SC_SETTLE_CYC cycles (96 at defaults).
- Invariants:
  - o_Tx_SC_en=1 implies o_Tx_CM_en=1.
  - o_tx_ready=1 implies both enables are 1.
  - o_dac_code is nonzero only in ON (or in SC_DN while ramping under the option below).

Optional Feature:
- Macro: TX_SEQ_RAMP_EN.
- Defined, in ON: o_dac_code slews toward i_dac_code by at most RAMP_STEP per cycle. When |diff| <= RAMP_STEP it lands exactly on the target. No overflow or underflow: compute in DAC_W+1 bits.
- Defined, in SC_DN: the code ramps to 0 first. o_Tx_SC_en stays 1 during the ramp and the counter is held. When the code reaches 0, o_Tx_SC_en drops and the settle count starts.
- Undefined: code steps as described in Behaviour; no ramp logic is instantiated.

Test Plan:
- Reset then req=1 at cycle 10, defaults -> CM_en rises at 11, SC_en rises at 75, ready rises at 107; o_busy=1 for cycles 11..106.
- In ON, drive i_dac_code=0x155 -> o_dac_code=0x155 one cycle later. Drop req -> ready=0, code=0 and SC_en=0 on the same edge; CM_en falls 32 cycles later; OFF 64 cycles after that.
- req pulse of 5 cycles from OFF -> CM_UP aborts to CM_DN; SC_en never asserts; OFF 64 cycles after the abort.
- Re-assert req during CM_DN -> no enable change until OFF; CM_en re-rises 1 cycle after OFF.
- Assert rst_n=0 asynchronously while in ON -> all outputs 0 without a clock edge; o_state=0.
- With TX_SEQ_RAMP_EN, RAMP_STEP=8, code 0 -> 20 -> o_dac_code sequence 8, 16, 20. On req drop: 12, 4, 0, then SC_en falls.
